// File: rtl/prog_seq_if.sv
// prog_seq_if: programming, run-control and status bundle for prog_seq_core
// master drives programming/control (prog_*, run, step, start); slave returns pc, prog_wptr, o_b, o_regs and flags
interface prog_seq_if #(
  parameter int WIDTH = 16,
  parameter int NREG = 4,
  parameter int PC_W = 4
);
  localparam int RA = $clog2(NREG);
  logic prog_en;
  logic prog_we;
  logic [2:0] prog_op;
  logic [RA-1:0] prog_dest;
  logic [RA-1:0] prog_src;
  logic [WIDTH-1:0] prog_imm;
  logic run;
  logic step;
  logic start;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] prog_wptr;
  logic [WIDTH-1:0] o_b;
  logic [NREG*WIDTH-1:0] o_regs;
  logic zero;
  logic carry;
  logic halted;
  modport master (
    output prog_en, prog_we, prog_op, prog_dest, prog_src, prog_imm, run, step, start,
    input pc, prog_wptr, o_b, o_regs, zero, carry, halted
  );
  modport slave (
    input prog_en, prog_we, prog_op, prog_dest, prog_src, prog_imm, run, step, start,
    output pc, prog_wptr, o_b, o_regs, zero, carry, halted
  );
endinterface

// File: rtl/prog_seq_core.sv
// prog_seq_core: programmable single-cycle sequencer with 8-opcode ISA, zero/carry flags and run/step/HALT control
// Ports: btn_adv = clock (rising edge), rst = async active-high reset,
//        bus.slave = programming inputs, run/step/start control, and pc/prog_wptr/o_b/o_regs/zero/carry/halted status
module prog_seq_core #(
  parameter int WIDTH = 16,
  parameter int NREG = 4,
  parameter int PC_W = 4
) (
  input logic btn_adv,
  input logic rst,
  prog_seq_if.slave bus
);
  localparam int RA = $clog2(NREG);
  localparam int IW = 3 + 2 * RA + WIDTH;
  localparam int DEPTH = 2 ** PC_W;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDI = 3'd2;
  localparam logic [2:0] OP_JMP = 3'd3;
  localparam logic [2:0] OP_JZ = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_OUT = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;
  typedef enum logic [1:0] {S_HALT, S_PROG, S_EXEC} state_t;
  state_t r_state, w_state_nx;
  logic [IW-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_regs [NREG];
  logic [PC_W-1:0] r_pc, r_wptr, w_pc_nx, w_pc_inc;
  logic [WIDTH-1:0] r_ob;
  logic r_zero, r_carry, r_step_q;
  logic [2:0] w_op;
  logic [RA-1:0] w_rd, w_rs;
  logic [WIDTH-1:0] w_imm, w_a, w_b, w_res;
  logic [WIDTH:0] w_sum, w_diff;
  logic w_en, w_wr, w_prog_wr;
  assign {w_op, w_rd, w_rs, w_imm} = r_mem[r_pc];
  assign w_a = r_regs[w_rd];
  assign w_b = r_regs[w_rs];
  // one extra bit holds the carry-out of ADD and the borrow of SUB
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_pc_inc = r_pc + 1'b1;
  // prog_en blocks retirement so an aborting edge leaves regs, flags and o_b untouched
  assign w_en = r_state == S_EXEC && !bus.prog_en && (bus.run || (bus.step && !r_step_q));
  assign w_wr = w_en && (w_op == OP_ADD || w_op == OP_LDI || w_op == OP_SUB);
  assign w_res = w_op == OP_ADD ? w_sum[WIDTH-1:0] : w_op == OP_SUB ? w_diff[WIDTH-1:0] : w_imm;
  assign w_prog_wr = r_state == S_PROG && bus.prog_en && bus.prog_we;
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx = r_pc;
    if (bus.prog_en) begin
      w_state_nx = S_PROG;
      w_pc_nx = '0;
    end else if (r_state == S_PROG || (r_state == S_HALT && bus.start)) begin
      w_state_nx = S_EXEC;
      w_pc_nx = '0;
    end else if (w_en) begin
      w_state_nx = w_op == OP_HALT ? S_HALT : S_EXEC;
      w_pc_nx = (w_op == OP_JMP || (w_op == OP_JZ && r_zero)) ? w_imm[PC_W-1:0] :
                w_op == OP_HALT ? r_pc : w_pc_inc;
    end
  end
  always_ff @(posedge btn_adv or posedge rst) begin
    if (rst) begin
      r_state <= S_HALT;
      r_pc <= '0;
      r_wptr <= '0;
      r_ob <= '0;
      r_zero <= 1'b0;
      r_carry <= 1'b0;
      r_step_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc <= w_pc_nx;
      r_step_q <= bus.step;
      if (w_prog_wr) begin
        r_mem[r_wptr] <= {bus.prog_op, bus.prog_dest, bus.prog_src, bus.prog_imm};
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_wr) begin
        r_regs[w_rd] <= w_res;
        r_zero <= w_res == '0;
      end
      if (w_wr && w_op != OP_LDI) r_carry <= w_op == OP_ADD ? w_sum[WIDTH] : w_diff[WIDTH];
      if (w_en && w_op == OP_OUT) r_ob <= w_a;
    end
  end
  assign bus.pc = r_pc;
  assign bus.prog_wptr = r_wptr;
  assign bus.o_b = r_ob;
  assign bus.zero = r_zero;
  assign bus.carry = r_carry;
  assign bus.halted = r_state == S_HALT;
  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign bus.o_regs[g*WIDTH +: WIDTH] = r_regs[g];
  end
endmodule

// File: tb/tb_prog_seq_core.sv
// tb_prog_seq_core: directed and randomized checks of prog_seq_core against an ISA-level model
module tb_prog_seq_core;
  localparam int W = 16;
  localparam int N = 4;
  localparam int P = 4;
  localparam int D = 16;
  localparam int M = 65536;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  prog_seq_if #(.WIDTH(W), .NREG(N), .PC_W(P)) bus ();
  prog_seq_core #(.WIDTH(W), .NREG(N), .PC_W(P)) dut (.btn_adv(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int m_mode;
  int m_pc, m_wptr, m_ob, m_z, m_c, m_stepq;
  int m_op [D];
  int m_rd [D];
  int m_rs [D];
  int m_imm [D];
  int m_reg [N];
  function automatic logic [N*W-1:0] m_flat();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = W'(m_reg[i]);
    return f;
  endfunction
  task automatic m_reset();
    m_mode = 0; m_pc = 0; m_wptr = 0; m_ob = 0; m_z = 0; m_c = 0; m_stepq = 0;
    for (int i = 0; i < D; i++) begin m_op[i] = 0; m_rd[i] = 0; m_rs[i] = 0; m_imm[i] = 0; end
    for (int i = 0; i < N; i++) m_reg[i] = 0;
  endtask
  task automatic m_exec();
    int op, rd, imm, a, b, npc;
    op = m_op[m_pc]; rd = m_rd[m_pc]; imm = m_imm[m_pc];
    a = m_reg[rd]; b = m_reg[m_rs[m_pc]]; npc = (m_pc + 1) % D;
    if (op == 1) begin m_c = int'(a + b >= M); m_reg[rd] = (a + b) % M; m_z = int'(m_reg[rd] == 0); end
    else if (op == 2) begin m_reg[rd] = imm; m_z = int'(imm == 0); end
    else if (op == 3) npc = imm % D;
    else if (op == 4 && m_z != 0) npc = imm % D;
    else if (op == 5) begin m_c = int'(a < b); m_reg[rd] = (a - b + M) % M; m_z = int'(m_reg[rd] == 0); end
    else if (op == 6) m_ob = a;
    else if (op == 7) begin m_mode = 0; npc = m_pc; end
    m_pc = npc;
  endtask
  task automatic m_clock();
    bit en;
    en = m_mode == 2 && !bus.prog_en && (bus.run || (bus.step && m_stepq == 0));
    if (bus.prog_en) begin
      if (m_mode == 1 && bus.prog_we) begin
        m_op[m_wptr] = int'(bus.prog_op); m_rd[m_wptr] = int'(bus.prog_dest);
        m_rs[m_wptr] = int'(bus.prog_src); m_imm[m_wptr] = int'(bus.prog_imm);
        m_wptr = (m_wptr + 1) % D;
      end
      m_mode = 1; m_pc = 0;
    end else if (m_mode == 1 || (m_mode == 0 && bus.start)) begin
      m_mode = 2; m_pc = 0;
    end else if (en) m_exec();
    m_stepq = int'(bus.step);
  endtask
  task automatic cyc();
    m_clock();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.prog_en = 0; bus.prog_we = 0; bus.prog_op = '0; bus.prog_dest = '0; bus.prog_src = '0;
    bus.prog_imm = '0; bus.run = 0; bus.step = 0; bus.start = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    #2;
    @(negedge clk);
    rst = 0;
    m_reset();
  endtask
  task automatic enter_prog();
    bus.prog_en = 1; bus.prog_we = 0;
    cyc();
  endtask
  task automatic wr(input int op, input int d, input int s, input int imm);
    bus.prog_en = 1; bus.prog_we = 1; bus.prog_op = 3'(op); bus.prog_dest = 2'(d);
    bus.prog_src = 2'(s); bus.prog_imm = 16'(imm);
    cyc();
  endtask
  task automatic leave_prog(input bit r);
    bus.prog_en = 0; bus.prog_we = 0; bus.run = r; bus.step = 0;
    cyc();
  endtask
  task automatic wait_halt(output int n);
    n = 0;
    while (!bus.halted && n < 100) begin cyc(); n++; end
  endtask
  task automatic load_basic();
    enter_prog();
    wr(2, 0, 0, 5); wr(2, 1, 0, 10); wr(1, 0, 1, 0); wr(6, 0, 0, 0); wr(7, 0, 0, 0);
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (bus.pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", bus.pc); end
    checks++; if (bus.prog_wptr !== 4'd0) begin errors++; $display("FAIL reset_wptr got %0d exp 0", bus.prog_wptr); end
    checks++; if (bus.o_b !== 16'd0) begin errors++; $display("FAIL reset_ob got %0h exp 0", bus.o_b); end
    checks++; if (bus.o_regs !== 64'd0) begin errors++; $display("FAIL reset_regs got %0h exp 0", bus.o_regs); end
    checks++; if ({bus.zero, bus.carry, bus.halted} !== 3'b001) begin errors++; $display("FAIL reset_flags got %b exp 001", {bus.zero, bus.carry, bus.halted}); end
    bus.run = 1;
    repeat (3) cyc();
    checks++; if ({bus.halted, bus.pc} !== 5'b1_0000) begin errors++; $display("FAIL reset_stay_halt got %b exp 10000", {bus.halted, bus.pc}); end
  endtask
  task automatic test_basic();
    do_reset();
    load_basic();
    checks++; if (bus.prog_wptr !== 4'd5) begin errors++; $display("FAIL basic_wptr got %0d exp 5", bus.prog_wptr); end
    leave_prog(1);
    repeat (4) cyc();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL basic_early_halt got %b exp 0", bus.halted); end
    cyc();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL basic_halt got %b exp 1", bus.halted); end
    checks++; if (bus.o_b !== 16'd15) begin errors++; $display("FAIL basic_ob got %0d exp 15", bus.o_b); end
    checks++; if (bus.o_regs[31:0] !== {16'd10, 16'd15}) begin errors++; $display("FAIL basic_regs got %0h exp a000f", bus.o_regs[31:0]); end
    checks++; if ({bus.zero, bus.carry, bus.pc, bus.prog_wptr} !== {2'b00, 4'd4, 4'd5}) begin errors++; $display("FAIL basic_state got z%b c%b pc%0d wp%0d exp z0 c0 pc4 wp5", bus.zero, bus.carry, bus.pc, bus.prog_wptr); end
  endtask
  task automatic test_overflow();
    int n;
    do_reset();
    enter_prog();
    wr(4, 0, 0, 5); wr(2, 0, 0, 'hFFFF); wr(2, 1, 0, 1); wr(1, 0, 1, 0); wr(7, 0, 0, 0); wr(5, 0, 1, 0); wr(7, 0, 0, 0);
    leave_prog(1);
    wait_halt(n);
    checks++; if (!bus.halted) begin errors++; $display("FAIL ovf_timeout got halted=%b exp 1", bus.halted); end
    checks++; if ({bus.o_regs[15:0], bus.zero, bus.carry, bus.pc} !== {16'd0, 2'b11, 4'd4}) begin errors++; $display("FAIL ovf_add got r0=%0h z%b c%b pc%0d exp r0=0 z1 c1 pc4", bus.o_regs[15:0], bus.zero, bus.carry, bus.pc); end
    bus.start = 1;
    cyc();
    bus.start = 0;
    wait_halt(n);
    checks++; if ({bus.o_regs[15:0], bus.zero, bus.carry, bus.pc} !== {16'hFFFF, 2'b01, 4'd6}) begin errors++; $display("FAIL ovf_sub got r0=%0h z%b c%b pc%0d exp r0=ffff z0 c1 pc6", bus.o_regs[15:0], bus.zero, bus.carry, bus.pc); end
  endtask
  task automatic test_countdown();
    int n;
    do_reset();
    enter_prog();
    wr(2, 0, 0, 3); wr(2, 1, 0, 1); wr(5, 0, 1, 0); wr(4, 0, 0, 5); wr(3, 0, 0, 2); wr(6, 1, 0, 0); wr(7, 0, 0, 0);
    leave_prog(1);
    wait_halt(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL loop_cycles got %0d exp 12", n); end
    checks++; if ({bus.o_b, bus.o_regs[15:0], bus.pc} !== {16'd1, 16'd0, 4'd6}) begin errors++; $display("FAIL loop_result got ob=%0h r0=%0h pc%0d exp ob=1 r0=0 pc6", bus.o_b, bus.o_regs[15:0], bus.pc); end
    checks++; if ({bus.zero, bus.carry} !== 2'b10) begin errors++; $display("FAIL loop_flags got %b exp 10", {bus.zero, bus.carry}); end
  endtask
  task automatic test_step();
    do_reset();
    load_basic();
    leave_prog(0);
    bus.step = 1;
    repeat (5) cyc();
    checks++; if ({bus.pc, bus.o_regs[15:0]} !== {4'd1, 16'd5}) begin errors++; $display("FAIL step_hold got pc%0d r0=%0h exp pc1 r0=5", bus.pc, bus.o_regs[15:0]); end
    repeat (4) begin bus.step = 0; cyc(); bus.step = 1; cyc(); end
    checks++; if ({bus.halted, bus.pc, bus.o_b} !== {1'b1, 4'd4, 16'd15}) begin errors++; $display("FAIL step_edges got h%b pc%0d ob%0d exp h1 pc4 ob15", bus.halted, bus.pc, bus.o_b); end
    bus.step = 0;
  endtask
  task automatic test_wrap();
    int n;
    do_reset();
    enter_prog();
    for (int i = 0; i < 17; i++)
      if (i == 0) wr(2, 0, 0, 7);
      else if (i == 1) wr(2, 1, 0, 3);
      else if (i == 2) wr(7, 0, 0, 0);
      else if (i == 16) wr(1, 3, 1, 0);
      else wr(0, 0, 0, 0);
    checks++; if (bus.prog_wptr !== 4'd1) begin errors++; $display("FAIL wrap_wptr got %0d exp 1", bus.prog_wptr); end
    leave_prog(1);
    wait_halt(n);
    checks++; if (bus.o_regs !== {16'd0, 16'd0, 16'd3, 16'd0}) begin errors++; $display("FAIL wrap_first got %0h exp 30000", bus.o_regs); end
    for (int k = 1; k <= 2; k++) begin
      bus.start = 1;
      cyc();
      checks++; if ({bus.halted, bus.pc} !== 5'b0_0000) begin errors++; $display("FAIL wrap_start got h%b pc%0d exp h0 pc0", bus.halted, bus.pc); end
      bus.start = 0;
      wait_halt(n);
      checks++; if (bus.o_regs[63:48] !== 16'(3 * k)) begin errors++; $display("FAIL wrap_keep got %0d exp %0d", bus.o_regs[63:48], 3 * k); end
    end
  endtask
  task automatic test_abort();
    do_reset();
    enter_prog();
    wr(2, 0, 0, 1); wr(1, 0, 0, 0); wr(3, 0, 0, 1);
    leave_prog(1);
    repeat (4) cyc();
    bus.prog_en = 1;
    cyc();
    checks++; if ({bus.o_regs[15:0], bus.pc, bus.halted, bus.prog_wptr} !== {16'd4, 4'd0, 1'b0, 4'd3}) begin errors++; $display("FAIL abort got r0=%0d pc%0d h%b wp%0d exp r0=4 pc0 h0 wp3", bus.o_regs[15:0], bus.pc, bus.halted, bus.prog_wptr); end
    bus.prog_en = 0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    enter_prog();
    wr(2, 0, 0, 9); wr(6, 0, 0, 0); wr(2, 1, 0, 2); wr(3, 0, 0, 3);
    leave_prog(1);
    for (int i = 0; i < 10 && bus.pc !== 4'd3; i++) cyc();
    checks++; if ({bus.pc, bus.o_b} !== {4'd3, 16'd9}) begin errors++; $display("FAIL mid_reach got pc%0d ob%0d exp pc3 ob9", bus.pc, bus.o_b); end
    #2;
    rst = 1;
    #1;
    checks++; if ({bus.pc, bus.o_b, bus.o_regs, bus.halted, bus.prog_wptr} !== {4'd0, 16'd0, 64'd0, 1'b1, 4'd0}) begin errors++; $display("FAIL mid_async got pc%0d ob%0h regs%0h h%b wp%0d exp all 0 h1", bus.pc, bus.o_b, bus.o_regs, bus.halted, bus.prog_wptr); end
    @(negedge clk);
    rst = 0;
    m_reset();
    bus.start = 1;
    cyc();
    bus.start = 0;
    repeat (20) cyc();
    checks++; if ({bus.pc, bus.o_b, bus.o_regs, bus.halted} !== {4'd4, 16'd0, 64'd0, 1'b0}) begin errors++; $display("FAIL mid_nop got pc%0d ob%0h regs%0h h%b exp pc4 0 0 h0", bus.pc, bus.o_b, bus.o_regs, bus.halted); end
    bus.run = 0;
  endtask
  task automatic test_random();
    int op;
    do_reset();
    enter_prog();
    for (int i = 0; i < D; i++) begin
      op = int'($urandom_range(0, 7));
      if (op == 7 && $urandom_range(0, 2) != 0) op = 0;
      wr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)));
    end
    leave_prog(1);
    for (int c = 0; c < 400; c++) begin
      bus.prog_en = $urandom_range(0, 99) < 3;
      bus.prog_we = 1'($urandom_range(0, 1));
      bus.prog_op = 3'($urandom_range(0, 6));
      bus.prog_dest = 2'($urandom_range(0, 3));
      bus.prog_src = 2'($urandom_range(0, 3));
      bus.prog_imm = 16'($urandom_range(0, M - 1));
      bus.run = $urandom_range(0, 2) == 0;
      bus.step = 1'($urandom_range(0, 1));
      bus.start = $urandom_range(0, 7) == 0;
      cyc();
      checks++; if ({bus.pc, bus.prog_wptr, bus.halted} !== {4'(m_pc), 4'(m_wptr), m_mode == 0}) begin errors++; $display("FAIL rnd_ctl c%0d got pc%0d wp%0d h%b exp pc%0d wp%0d h%b", c, bus.pc, bus.prog_wptr, bus.halted, m_pc, m_wptr, m_mode == 0); end
      checks++; if (bus.o_regs !== m_flat()) begin errors++; $display("FAIL rnd_regs c%0d got %0h exp %0h", c, bus.o_regs, m_flat()); end
      checks++; if ({bus.o_b, bus.zero, bus.carry} !== {16'(m_ob), m_z != 0, m_c != 0}) begin errors++; $display("FAIL rnd_out c%0d got ob%0h z%b c%b exp ob%0h z%0d c%0d", c, bus.o_b, bus.zero, bus.carry, m_ob, m_z, m_c); end
    end
    idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
  initial begin
    idle();
    m_reset();
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_countdown();
    test_step();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_seq_core.md
Name: prog_seq_core

Overview:
Parametrised successor to the fixed 4-register ADD/JUMP processor. It adds a loadable program memory, NREG registers of WIDTH bits, and an 8-opcode ISA with zero/carry flags and conditional jump. It also adds run/single-step control with HALT. The block sits under the board top: the DIP/button layer drives the programming and step ports, and LED/7-seg logic consumes pc, o_b and the register file.

Parameters:
WIDTH, 16, datapath and register width (>=4).
NREG, 4, register count, power of 2 (>=2). RA = clog2(NREG).
PC_W, 4, PC width; program depth = 2**PC_W.

Ports:
btn_adv  in  1  system clock (rising edge).
rst  in  1  asynchronous, active-high reset.
prog_en  in  1  program mode; highest priority.
prog_we  in  1  write one instruction at prog_wptr (only while prog_en=1).
prog_op  in  3  opcode to write.
prog_dest  in  RA  destination register field.
prog_src  in  RA  source register field.
prog_imm  in  WIDTH  immediate / jump target.
run  in  1  1 = execute one instruction every clock.
step  in  1  with run=0, a 0->1 edge executes exactly one instruction.
start  in  1  in HALT state: restart at pc=0 on the next clock.
pc  out  PC_W  current program counter.
prog_wptr  out  PC_W  next program write address.
o_b  out  WIDTH  output latch written by OUT.
o_regs  out  NREG*WIDTH  flattened registers; r0 in bits [WIDTH-1:0].
zero  out  1  zero flag.
carry  out  1  carry/borrow flag.
halted  out  1  high in HALT state.

Behaviour:
- Reset (async, any state): pc=0, prog_wptr=0, o_b=0, all regs=0, zero=0, carry=0, all memory entries=NOP, state=HALT, halted=1, step edge-detect register=0.
- States: HALT, PROG, EXEC.
  - Any state with prog_en=1 -> PROG next clock. In PROG: pc held at 0, no execution.
  - PROG with prog_en=0 -> EXEC, pc=0. prog_wptr is not cleared; it is cleared only by reset.
  - HALT with start=1 (prog_en=0) -> EXEC, pc=0. Registers and flags are kept.
  - EXEC executing HALT -> HALT, pc unchanged.
- Program write, in PROG with prog_we=1 on a clock:
  - mem[prog_wptr] <= {op, dest, src, imm}.
  - prog_wptr increments and wraps 2**PC_W-1 -> 0. Wrapping overwrites entry 0.
  - prog_we outside PROG is ignored.
- Execute enable in EXEC = run | (step & ~step_q). step_q is registered every clock. run=1 makes step a don't-care.
- Each enabled clock retires one instruction at mem[pc], single-cycle, with results visible after that edge.
- Default pc update is pc+1 mod 2**PC_W, so a program with no HALT wraps to 0.
- Opcodes (rd=dest, rs=src):
  - 000 NOP: no effect.
  - 001 ADD: rd = rd+rs mod 2**WIDTH; carry = carry-out; zero = (result==0).
  - 010 LDI: rd = imm; zero = (imm==0); carry unchanged.
  - 011 JMP: pc = imm[PC_W-1:0].
  - 100 JZ: if zero then pc = imm[PC_W-1:0], else pc+1.
  - 101 SUB: rd = rd-rs mod 2**WIDTH; carry = borrow (rd<rs unsigned); zero = (result==0).
  - 110 OUT: o_b = rd.
  - 111 HALT: enter HALT.
- rd==rs is legal: ADD r,r doubles the register; SUB r,r gives 0 with zero=1.
- JMP/JZ to the current pc is a legal spin loop.
- Outputs are registered or direct from state; no combinational input-to-output path.
- prog_en asserted mid-execution aborts at the next edge. That edge retires no instruction; registers, flags and o_b are kept.

Test Plan:
- Basic program. Program LDI r0,5; LDI r1,10; ADD r0,r1; OUT r0; HALT, then drop prog_en with run=1 -> after 5 clocks o_b=15, r0=15, zero=0, carry=0, halted=1, pc=4. prog_wptr=5 throughout.
- Overflow. Program LDI r0,0xFFFF; LDI r1,1; ADD r0,r1; HALT -> r0=0, zero=1, carry=1. Follow with SUB r0,r1 -> r0=0xFFFF, carry=1, zero=0.
- Countdown loop. Program LDI r0,3; LDI r1,1; SUB r0,r1; JZ 5; JMP 2; OUT r1; HALT -> loop body runs 3 times; o_b=1, r0=0, halted=1.
- Step mode. Same program as the basic case, run=0. Hold step high for 5 clocks -> exactly one instruction retires (pc 0->1). Four further 0->1 edges -> HALT.
- Wrap and restart. Write 17 instructions with 2**PC_W=16 -> prog_wptr=1 and entry 0 holds the 17th. In HALT, pulse start -> pc=0 and execution resumes with registers preserved.
- Reset mid-run. Assert rst asynchronously while in EXEC at pc=3 -> pc=0, o_b=0, regs=0, halted=1 immediately, and memory reads back all NOP (no register change on run).
